// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests a 32-byte block as an even/odd line pair,
// captures both lines, then streams their words into a small instruction queue.
//
// state | meaning
// REQ   | waiting for both lines of the current block (or a fetch fault)
// PUSH  | enqueueing words pc[4:2]..7 of the captured block
// HALT  | fault marker queued; idle until a redirect restarts fetch
module ifetch_unit #(
  parameter int          CL_SIZE  = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        addr_even,
  output logic [31:0]        addr_odd,
  input  logic               hit_even,
  input  logic               hit_odd,
  input  logic [CL_SIZE-1:0] cl_even,
  input  logic [CL_SIZE-1:0] cl_odd,
  input  logic [31:0]        addr_out_even,
  input  logic [31:0]        addr_out_odd,
  input  logic               stall,
  input  logic               exception,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_exc
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {REQ, PUSH, HALT} state_t;

  state_t                state, state_nxt;
  logic [31:0]           pc;
  logic                  flag_even, flag_odd;
  logic [CL_SIZE-1:0]    line_even, line_odd;
  logic [31:0]           q_inst [FQ_DEPTH];
  logic [31:0]           q_pc   [FQ_DEPTH];
  logic                  q_exc  [FQ_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic                  full, do_deq;
  logic                  cap_even, cap_odd;
  logic                  set_even, set_odd, clr_flags;
  logic                  do_enq, enq_exc, pc_inc;
  logic [2*CL_SIZE-1:0]  blk_data;
  logic [31:0]           blk_word;
  logic                  unused_bits;

  assign unused_bits = ^{addr_out_even[3:0], addr_out_odd[3:0], redirect_pc[1:0]};

  assign addr_even  = {pc[31:5], 5'h00};
  assign addr_odd   = {pc[31:5], 5'h10};
  assign full       = (count == FULL_CNT);
  assign inst_valid = (count != '0);
  assign do_deq     = inst_valid && inst_ready;
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign inst_exc   = q_exc[rd_ptr];

  // A returned line only counts when its tag names the line we asked for.
  assign cap_even = hit_even && !stall && (addr_out_even[31:4] == addr_even[31:4]);
  assign cap_odd  = hit_odd  && !stall && (addr_out_odd[31:4]  == addr_odd[31:4]);

  assign blk_data = {line_odd, line_even};
  assign blk_word = blk_data[{pc[4:2], 5'b0} +: 32];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // Next-state and control decode; a redirect overrides everything else.
  always_comb begin
    state_nxt = state;
    set_even  = 1'b0;
    set_odd   = 1'b0;
    clr_flags = 1'b0;
    do_enq    = 1'b0;
    enq_exc   = 1'b0;
    pc_inc    = 1'b0;
    if (redirect_valid) begin
      state_nxt = REQ;
    end else begin
      unique case (state)
        REQ: begin
          if (exception && !stall) begin
            // Fault wins over captures; wait for room to queue the marker.
            if (!full) begin
              do_enq    = 1'b1;
              enq_exc   = 1'b1;
              state_nxt = HALT;
            end
          end else begin
            set_even = cap_even;
            set_odd  = cap_odd;
            if ((flag_even || cap_even) && (flag_odd || cap_odd)) begin
              clr_flags = 1'b1;
              state_nxt = PUSH;
            end
          end
        end
        PUSH: begin
          // Full queue stalls here; a pop this cycle does not make room until next.
          if (!full) begin
            do_enq = 1'b1;
            pc_inc = 1'b1;
            if (pc[4:2] == 3'd7) state_nxt = REQ;
          end
        end
        HALT: ;
        default: state_nxt = REQ;
      endcase
    end
  end

  // Fetch PC, line capture and instruction queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= {RESET_PC[31:2], 2'b00};
      flag_even <= 1'b0;
      flag_odd  <= 1'b0;
      line_even <= '0;
      line_odd  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
        q_exc[i]  <= 1'b0;
      end
    end else if (redirect_valid) begin
      pc        <= {redirect_pc[31:2], 2'b00};
      flag_even <= 1'b0;
      flag_odd  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (clr_flags) begin
        flag_even <= 1'b0;
        flag_odd  <= 1'b0;
      end else begin
        if (set_even) flag_even <= 1'b1;
        if (set_odd)  flag_odd  <= 1'b1;
      end
      if (set_even) line_even <= cl_even;
      if (set_odd)  line_odd  <= cl_odd;
      if (pc_inc) pc <= pc + 32'd4;
      if (do_enq) begin
        q_inst[wr_ptr] <= enq_exc ? 32'h0 : blk_word;
        q_pc[wr_ptr]   <= pc;
        q_exc[wr_ptr]  <= enq_exc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order expected-instruction model.
module tb_ifetch_unit;

  localparam int CL = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr_even, addr_odd;
  logic          hit_even, hit_odd;
  logic [CL-1:0] cl_even, cl_odd;
  logic [31:0]   addr_out_even, addr_out_odd;
  logic          stall, exception, redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid, inst_ready;
  logic [31:0]   inst, inst_pc;
  logic          inst_exc;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  ent_t model_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.CL_SIZE(CL), .RESET_PC(32'h20), .FQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .addr_even(addr_even), .addr_odd(addr_odd),
    .hit_even(hit_even), .hit_odd(hit_odd),
    .cl_even(cl_even), .cl_odd(cl_odd),
    .addr_out_even(addr_out_even), .addr_out_odd(addr_out_odd),
    .stall(stall), .exception(exception),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_exc(inst_exc)
  );

  // Memory contents: each word is derived from its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present both lines of the block holding 'start' for one cycle;
  // optionally record the words the queue must later deliver.
  task automatic serve(input logic [31:0] start, input bit expect_it);
    logic [31:0] base;
    base = {start[31:5], 5'h00};
    for (int i = 0; i < 4; i++) begin
      cl_even[32*i +: 32] = mem_word(base + 32'(4*i));
      cl_odd[32*i +: 32]  = mem_word(base + 32'(16 + 4*i));
    end
    addr_out_even = base;
    addr_out_odd  = base + 32'h10;
    hit_even = 1'b1;
    hit_odd  = 1'b1;
    if (expect_it)
      for (int k = int'(start[4:2]); k < 8; k++)
        model_q.push_back('{mem_word(base + 32'(4*k)), base + 32'(4*k), 1'b0});
    tick();
    hit_even = 1'b0;
    hit_odd  = 1'b0;
    cl_even  = '1;
    cl_odd   = '1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (addr_even !== a && n < 100) begin
      tick();
      n++;
    end
    check("wait_addr", addr_even, a);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, inst_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((model_q.size() != 0 || inst_valid !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check("drain_model_empty", 32'(model_q.size()), 0);
    check("drain_inst_valid", inst_valid, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_exc", inst_exc, 0);
    check("rst_addr_even", addr_even, 32'h20);
    check("rst_addr_odd", addr_odd, 32'h30);
  endtask

  // Every accepted head entry must be the next one the model expects.
  always @(negedge clk) begin
    if (!rst && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (model_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry actual_pc=%h required=none", inst_pc);
      end else begin
        ent_t e;
        e = model_q.pop_front();
        check("entry_inst", inst, e.inst);
        check("entry_pc", inst_pc, e.pc);
        check("entry_exc", inst_exc, e.exc);
      end
      pops++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, p0;
    bit seen;
    rst = 1'b1;
    hit_even = 0; hit_odd = 0; cl_even = '0; cl_odd = '0;
    addr_out_even = 0; addr_out_odd = 0; stall = 0; exception = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    ticks(2);
    rst = 1'b0;
    check_reset_vals();

    // Aligned block, both lines in one cycle.
    inst_ready = 1'b1;
    serve(32'h20, 1);
    n = 0; seen = 0;
    while (addr_even !== 32'h40 && n < 50) begin
      if (inst_valid === 1'b1 && !seen) begin
        seen = 1;
        check("first_pc_lit", inst_pc, 32'h20);
        check("first_inst_lit", inst, 32'h0020_BEEF);
      end
      tick();
      n++;
    end
    check("seen_first", 32'(seen), 1);
    check("cycles_to_next_blk", 32'(n), 8);
    check("addr_odd_next_blk", addr_odd, 32'h50);
    drain();

    // Lines in different cycles, with a mistagged odd hit in between.
    cl_even = '0;
    for (int i = 0; i < 4; i++) cl_even[32*i +: 32] = mem_word(32'h40 + 32'(4*i));
    addr_out_even = 32'h40;
    hit_even = 1'b1;
    for (int k = 0; k < 8; k++) model_q.push_back('{mem_word(32'h40 + 32'(4*k)), 32'h40 + 32'(4*k), 1'b0});
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      hit_even = 1'b0;
      cl_even  = '1;
      hit_odd  = 1'b0;
      if (c == 1) begin
        hit_odd = 1'b1; addr_out_odd = 32'h130; cl_odd = {4{32'hDEAD_0000}};
      end else if (c == 3) begin
        hit_odd = 1'b1; addr_out_odd = 32'h50;
        for (int i = 0; i < 4; i++) cl_odd[32*i +: 32] = mem_word(32'h50 + 32'(4*i));
      end
      if (inst_valid === 1'b1 && first < 0) first = c;
    end
    check("split_hit_latency", 32'(first), 5);
    drain();

    // Queue fills: second block holds at its first word until space frees.
    inst_ready = 1'b0;
    serve(32'h60, 1);
    wait_addr(32'h80);
    serve(32'h80, 1);
    ticks(20);
    check("full_valid", inst_valid, 1);
    check("full_pc_held", addr_even, 32'h80);
    check("full_head_pc", inst_pc, 32'h60);
    p0 = pops;
    inst_ready = 1'b1;
    wait_addr(32'hA0);
    drain();
    check("full_pop_count", 32'(pops - p0), 16);

    // Redirect into mid-block while the queue holds entries.
    inst_ready = 1'b0;
    serve(32'hA0, 0);
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFF00_0028;
    model_q.delete();
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", inst_valid, 0);
    check("redir_addr_even", addr_even, 32'hFF00_0020);
    check("redir_addr_odd", addr_odd, 32'hFF00_0030);
    inst_ready = 1'b1;
    serve(32'hFF00_0028, 1);
    wait_valid("redir_wait_valid");
    check("redir_first_pc_lit", inst_pc, 32'hFF00_0028);
    wait_addr(32'hFF00_0040);
    drain();

    // Fetch fault: one marker, then nothing until redirected.
    exception = 1'b1;
    model_q.push_back('{32'h0, 32'hFF00_0040, 1'b1});
    tick();
    exception = 1'b0;
    p0 = pops;
    wait_valid("exc_wait_valid");
    check("exc_flag_lit", inst_exc, 1);
    check("exc_pc_lit", inst_pc, 32'hFF00_0040);
    check("exc_inst_lit", inst, 0);
    for (int r = 0; r < 3; r++) serve(32'hFF00_0040, 0);
    ticks(10);
    check("exc_single_entry", 32'(pops - p0), 1);
    check("exc_halt_idle", inst_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    serve(32'h100, 1);
    wait_addr(32'h120);
    drain();

    // Stall masks hits; redirect discards coincident hits.
    stall = 1'b1;
    for (int r = 0; r < 3; r++) serve(32'h120, 0);
    stall = 1'b0;
    ticks(10);
    check("stall_no_capture", inst_valid, 0);
    check("stall_addr_held", addr_even, 32'h120);
    for (int i = 0; i < 4; i++) begin
      cl_even[32*i +: 32] = mem_word(32'h120 + 32'(4*i));
      cl_odd[32*i +: 32]  = mem_word(32'h130 + 32'(4*i));
    end
    addr_out_even = 32'h120; addr_out_odd = 32'h130;
    hit_even = 1'b1; hit_odd = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    tick();
    hit_even = 1'b0; hit_odd = 1'b0; redirect_valid = 1'b0;
    check("redir_hit_addr_even", addr_even, 32'h2000);
    check("redir_hit_addr_odd", addr_odd, 32'h2010);
    ticks(5);
    check("redir_hit_discarded", inst_valid, 0);
    serve(32'h2000, 1);
    wait_addr(32'h2020);
    drain();

    // Reset in the middle of a block.
    inst_ready = 1'b0;
    serve(32'h2020, 0);
    ticks(3);
    rst = 1'b1;
    model_q.delete();
    tick();
    rst = 1'b0;
    check_reset_vals();
    inst_ready = 1'b1;
    serve(32'h20, 1);
    wait_addr(32'h40);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
